// File: rtl/unibus_pkg.sv
// Shared types and constants for the Unibus priority arbiter.
package unibus_pkg;
  typedef enum logic [1:0] {IDLE, GRANT, SACKED, MASTER} arb_state_e;

  localparam int BR_LVL_BASE  = 4;
  localparam int BR_LVLS      = 4;
  localparam int SACK_TO_DFLT = 'o400;
endpackage

// File: rtl/unibus_prio_enc.sv
// Rotating priority encoder: first set request at or after start_i wins.
module unibus_prio_enc #(
  parameter int W  = 4,
  parameter int SW = (W > 1) ? $clog2(W) : 1
) (
  input  logic [W-1:0]  req_i,
  input  logic [SW-1:0] start_i,
  output logic [W-1:0]  gnt_o,
  output logic          vld_o
);
  logic [2*W-1:0] req_dbl, gnt_dbl;
  logic [W-1:0]   rot, rot_oh;
  logic           found;

  // Rotate so start_i lands on bit 0, pick lowest, rotate back.
  assign req_dbl = {req_i, req_i} >> start_i;
  assign rot     = req_dbl[W-1:0];

  always_comb begin
    rot_oh = '0;
    found  = 1'b0;
    for (int i = 0; i < W; i++) begin
      if (rot[i] && !found) begin
        rot_oh[i] = 1'b1;
        found     = 1'b1;
      end
    end
  end

  assign gnt_dbl = {rot_oh, rot_oh} << start_i;
  assign gnt_o   = gnt_dbl[2*W-1:W];
  assign vld_o   = |req_i;
endmodule

// File: rtl/unibus_arb.sv
// Unibus NPR/BR grant arbiter with SACK/BBSY handshake and no-SACK timeout.
// Define UNIBUS_ARB_NPR_RR_EN for round-robin NPR selection.
module unibus_arb import unibus_pkg::*; #(
  parameter int NPR_N   = 4,
  parameter int BR_N    = 2,
  parameter int SACK_TO = SACK_TO_DFLT,
  parameter int CNT_W   = 10
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                bus_init,
  input  logic [NPR_N-1:0]    npr_req,
  input  logic [4*BR_N-1:0]   br_req,
  input  logic [2:0]          cpu_pri,
  input  logic                cpu_br_ok,
  input  logic                bus_sack,
  input  logic                bus_bbsy,
  input  logic                bus_ssyn,
  output logic [NPR_N-1:0]    npr_gnt,
  output logic [4*BR_N-1:0]   br_gnt,
  output logic                cpu_hold,
  output logic                sack_timeout
);
  localparam int NPW = (NPR_N > 1) ? $clog2(NPR_N) : 1;

  arb_state_e                   state_q, state_d;
  logic [NPR_N-1:0]             npr_gnt_q, npr_gnt_d, npr_oh;
  logic [4*BR_N-1:0]            br_gnt_q, br_gnt_d, br_pick;
  logic                         cpu_hold_q, cpu_hold_d;
  logic                         sack_to_q, sack_to_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d;
  logic [NPW-1:0]               npr_start;
  logic                         npr_vld, br_hit, req_held, to_hit;
  logic [BR_LVLS-1:0][BR_N-1:0] lvl_oh;
  logic [BR_LVLS-1:0]           lvl_vld;

  unibus_prio_enc #(.W(NPR_N)) u_npr_enc (
    .req_i(npr_req), .start_i(npr_start), .gnt_o(npr_oh), .vld_o(npr_vld)
  );

  for (genvar l = 0; l < BR_LVLS; l++) begin : g_br
    unibus_prio_enc #(.W(BR_N)) u_enc (
      .req_i(br_req[BR_N*l +: BR_N]), .start_i('0), .gnt_o(lvl_oh[l]), .vld_o(lvl_vld[l])
    );
  end

  // Highest level above CPU priority wins; masked levels are simply not seen.
  always_comb begin
    br_pick = '0;
    br_hit  = 1'b0;
    for (int l = BR_LVLS-1; l >= 0; l--) begin
      if (!br_hit && lvl_vld[l] && (l + BR_LVL_BASE > int'(cpu_pri))) begin
        br_pick[BR_N*l +: BR_N] = lvl_oh[l];
        br_hit = 1'b1;
      end
    end
  end

`ifdef UNIBUS_ARB_NPR_RR_EN
  logic [NPW-1:0] ptr_q, ptr_d;

  assign npr_start = (ptr_q == NPW'(NPR_N-1)) ? '0 : ptr_q + 1'b1;

  // Only a transfer that reached SACK counts as serviced.
  always_comb begin
    ptr_d = ptr_q;
    if (state_q == GRANT && state_d == SACKED)
      for (int i = 0; i < NPR_N; i++)
        if (npr_gnt_q[i]) ptr_d = NPW'(i);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)      ptr_q <= NPW'(NPR_N-1);
    else if (bus_init) ptr_q <= NPW'(NPR_N-1);
    else               ptr_q <= ptr_d;
  end
`else
  assign npr_start = '0;
`endif

  assign req_held = |(npr_gnt_q & npr_req) | |(br_gnt_q & br_req);
  assign to_hit   = (state_q == GRANT) && !bus_sack && req_held &&
                    (cnt_q == CNT_W'(SACK_TO-1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      npr_gnt_q  <= '0;
      br_gnt_q   <= '0;
      cpu_hold_q <= 1'b0;
      sack_to_q  <= 1'b0;
      cnt_q      <= '0;
    end else if (bus_init) begin
      state_q    <= IDLE;
      npr_gnt_q  <= '0;
      br_gnt_q   <= '0;
      cpu_hold_q <= 1'b0;
      sack_to_q  <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      npr_gnt_q  <= npr_gnt_d;
      br_gnt_q   <= br_gnt_d;
      cpu_hold_q <= cpu_hold_d;
      sack_to_q  <= sack_to_d;
      cnt_q      <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (npr_vld || (cpu_br_ok && br_hit)) state_d = GRANT;
      end
      GRANT: begin
        cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
        if (bus_sack)       state_d = SACKED;
        else if (!req_held) state_d = IDLE;
        else if (to_hit)    state_d = IDLE;
      end
      SACKED:  if (!bus_sack) state_d = bus_bbsy ? MASTER : IDLE;
      MASTER:  if (!bus_bbsy && !bus_ssyn) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Grant is loaded from IDLE and held only while staying in GRANT.
  always_comb begin
    npr_gnt_d  = '0;
    br_gnt_d   = '0;
    cpu_hold_d = (state_d != IDLE);
    sack_to_d  = to_hit;
    case (state_q)
      IDLE: begin
        if (npr_vld)        npr_gnt_d = npr_oh;
        else if (cpu_br_ok) br_gnt_d  = br_pick;
      end
      GRANT: begin
        if (state_d == GRANT) begin
          npr_gnt_d = npr_gnt_q;
          br_gnt_d  = br_gnt_q;
        end
      end
      default: ;
    endcase
  end

  assign npr_gnt      = npr_gnt_q;
  assign br_gnt       = br_gnt_q;
  assign cpu_hold     = cpu_hold_q;
  assign sack_timeout = sack_to_q;
endmodule

// File: doc/unibus_arb.md
Name: unibus_arb

Overview:
- Unibus priority arbiter; sits beside the CPU and owns NPG/BG grant generation for the shared bus slaves (M9312 boot ROM, memory, I/O pages).
- Arbitrates NPR (DMA) requests and BR4–BR7 interrupt requests; BR requests are gated by CPU priority and the instruction-boundary strobe.
- Runs the SACK/BBSY handshake and a no-SACK timeout.
- Only one grant is outstanding at any time.

Parameters:
- NPR_N, 4, number of NPR requesters; index 0 has the highest priority (electrically nearest).
- BR_N, 2, requesters per BR level; index 0 has the highest priority within its level.
- SACK_TO, 'o400, clk cycles a grant may stay unacknowledged before it is withdrawn.
- CNT_W, 10, width of the timeout counter; must satisfy SACK_TO < 2**CNT_W.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- bus_init  in  1  Unibus INIT; synchronous clear, same effect as reset.
- npr_req  in  NPR_N  NPR request lines.
- br_req  in  4*BR_N  BR requests; slice [BR_N*(L-4) +: BR_N] belongs to level L.
- cpu_pri  in  3  CPU PSW priority, bits 7:5.
- cpu_br_ok  in  1  1-cycle strobe at the CPU instruction boundary.
- bus_sack  in  1  wired-OR SACK.
- bus_bbsy  in  1  wired-OR BBSY.
- bus_ssyn  in  1  wired-OR SSYN.
- npr_gnt  out  NPR_N  one-hot NPG.
- br_gnt  out  4*BR_N  one-hot BG, same layout as br_req.
- cpu_hold  out  1  CPU must not start a new bus cycle.
- sack_timeout  out  1  1-cycle pulse when a grant is withdrawn without SACK.

Behaviour:
- Reset (reset_n low, or bus_init high on a clk edge):
  - state = IDLE.
  - npr_gnt = 0, br_gnt = 0, cpu_hold = 0, sack_timeout = 0, timeout counter = 0.
- All outputs are registered.
- IDLE:
  - If any npr_req is set: grant the lowest-index requester; go to GRANT next cycle.
  - Otherwise, on a cycle where cpu_br_ok=1:
    - select the highest level L in 7..4 whose slice is nonzero and where L > cpu_pri;
    - grant the lowest index in that slice; go to GRANT.
  - NPR always beats BR in the same cycle.
  - BR requests with L <= cpu_pri are ignored; they are never latched.
- GRANT:
  - The grant is held; cpu_hold=1; the counter increments every cycle.
  - bus_sack=1: drop the grant next cycle; go to SACKED.
  - Requester drops its req before SACK: drop the grant; return to IDLE; no timeout pulse.
  - Counter reaches SACK_TO-1: drop the grant; pulse sack_timeout; return to IDLE.
  - Grants are never re-targeted while in GRANT, even if a higher-priority request arrives.
- SACKED:
  - cpu_hold=1; wait for bus_sack=0 with bus_bbsy=1 (device has become master); go to MASTER.
  - SACK dropping without BBSY counts as an aborted transfer; return to IDLE.
- MASTER:
  - cpu_hold=1; wait for bus_bbsy=0 and bus_ssyn=0; go to IDLE.
  - cpu_hold deasserts on that same transition.
- Grant latency: one clk from request sampled in IDLE to grant high.
  - A request arriving the same cycle the FSM enters IDLE is seen the following cycle.
- One-hot invariant: at most one bit set across npr_gnt|br_gnt in every cycle.
- Counter clears on every entry to GRANT and saturates; it does not wrap.

Optional Feature:
- Macro: UNIBUS_ARB_NPR_RR_EN.
- Defined:
  - NPR selection is round-robin.
  - A pointer records the last serviced NPR index; search starts at pointer+1 mod NPR_N.
  - The pointer updates on the SACKED entry only (timeouts do not advance it).
  - Reset pointer = NPR_N-1, so the first search starts at index 0.
- Undefined: fixed priority, lowest index wins. BR selection is fixed priority either way.

Decomposition:
- Package unibus_pkg:
  - FSM state enum (IDLE, GRANT, SACKED, MASTER);
  - BR level base constant 4;
  - default SACK_TO.
- One sub-module: unibus_prio_enc.
  - Parameterized width; request vector plus optional rotate start → one-hot plus valid.
  - Instantiated once for NPR and once per BR level.

Test Plan:
- npr_req=4'b0110 in IDLE → npr_gnt=4'b0010 one clk later; SACK at +3 → grant 0 next clk; BBSY high / SACK low → MASTER; BBSY and SSYN low → IDLE with cpu_hold=0.
- cpu_pri=5, BR5 and BR6 idx1 requesting, cpu_br_ok pulse → br_gnt bit BR_N*2+1 set; BR5 is never granted while cpu_pri=5.
- npr_req=4'b0001 and BR7 request in the same cpu_br_ok cycle → npr_gnt=1, br_gnt=0.
- Grant with no SACK for SACK_TO='o400 cycles → grant drops at cycle 'o400; sack_timeout pulses once; FSM in IDLE.
- reset_n low while in MASTER → all outputs 0 immediately (asynchronous); bus_init high in GRANT → IDLE at next edge.
- With UNIBUS_ARB_NPR_RR_EN, npr_req held at 4'b1111 → grants in order 0,1,2,3,0 across five complete transfers.
